// File: rtl/alu_chain_pkg.sv
// Shared types and constants for the multi-word ALU sequencer.
// Function-select codes follow the 74181-style encoding of ALU32.
package alu_chain_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       ALU_M_ARITH = 1'b0;
  localparam logic       ALU_M_LOGIC = 1'b1;
  localparam logic [3:0] ALU_S_ADD   = 4'b1001;
  localparam logic [3:0] ALU_S_SUB   = 4'b0110;
  localparam logic [3:0] ALU_S_AND   = 4'b1011;
  localparam logic [3:0] ALU_S_OR    = 4'b1110;
  localparam logic [3:0] ALU_S_XOR   = 4'b0110;

endpackage

// File: rtl/alu_chain_flags.sv
// Carry chaining, zero accumulation and top-word flag capture for alu_chain_seq.
// Optional sticky overflow flag is built when ALU_CHAIN_STICKY_V_EN is defined.
module alu_chain_flags
  import alu_chain_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_first,
  input  logic i_last,
  input  logic i_alu_c,
  input  logic i_alu_n,
  input  logic i_alu_v,
  input  logic i_alu_z,
`ifdef ALU_CHAIN_STICKY_V_EN
  input  logic i_done_hs,
  input  logic i_v_clr,
  output logic o_v_sticky,
`endif
  output logic o_prev_c,
  output logic o_rsp_c,
  output logic o_rsp_n,
  output logic o_rsp_v,
  output logic o_rsp_z
);

  logic r_prev_c;
  logic r_z_acc;
  logic r_c;
  logic r_n;
  logic r_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_c <= 1'b0;
      r_z_acc  <= 1'b0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
    end else if (i_run) begin
      r_prev_c <= i_alu_c;
      // Word 0 restarts the accumulator so a previous result never leaks in.
      r_z_acc  <= i_first ? i_alu_z : (r_z_acc & i_alu_z);
      if (i_last) begin
        r_c <= i_alu_c;
        r_n <= i_alu_n;
        r_v <= i_alu_v;
      end
    end
  end

  assign o_prev_c = r_prev_c;
  assign o_rsp_c  = r_c;
  assign o_rsp_n  = r_n;
  assign o_rsp_v  = r_v;
  assign o_rsp_z  = r_z_acc;

`ifdef ALU_CHAIN_STICKY_V_EN
  logic r_v_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_sticky <= 1'b0;
    end else if (i_done_hs && r_v) begin
      r_v_sticky <= 1'b1;
    end else if (i_v_clr) begin
      r_v_sticky <= 1'b0;
    end
  end

  assign o_v_sticky = r_v_sticky;
`endif

endmodule

// File: rtl/alu_chain_seq.sv
// Issues a WORDS x 32-bit operation to an external 32-bit ALU one word per cycle,
// chaining carry and assembling the wide result. Sticky-V option: ALU_CHAIN_STICKY_V_EN.
module alu_chain_seq
  import alu_chain_pkg::*;
#(
  parameter int WORDS     = 2,
  parameter bit CARRY_INV = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ALU_W*WORDS-1:0] req_a,
  input  logic [ALU_W*WORDS-1:0] req_b,
  input  logic [3:0]             req_S,
  input  logic                   req_M,
  input  logic                   req_cin,
  input  logic                   req_chain,
  output logic [ALU_W-1:0]       alu_a,
  output logic [ALU_W-1:0]       alu_b,
  output logic [3:0]             alu_S,
  output logic                   alu_M,
  output logic                   alu_cin,
  input  logic [ALU_W-1:0]       alu_do,
  input  logic                   alu_C,
  input  logic                   alu_N,
  input  logic                   alu_V,
  input  logic                   alu_Z,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ALU_W*WORDS-1:0] rsp_do,
  output logic                   rsp_C,
  output logic                   rsp_N,
  output logic                   rsp_V,
`ifdef ALU_CHAIN_STICKY_V_EN
  input  logic                   v_clr,
  output logic                   v_sticky,
`endif
  output logic                   rsp_Z
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [ALU_W*WORDS-1:0]   r_a;
  logic [ALU_W*WORDS-1:0]   r_b;
  logic [3:0]               r_s;
  logic                     r_m;
  logic                     r_cin;
  logic                     r_chain;
  logic                     r_rsp_valid;
  logic [ALU_W-1:0]         r_rsp_word [WORDS];
  logic [ALU_W-1:0]         w_a_word   [WORDS];
  logic [ALU_W-1:0]         w_b_word   [WORDS];
  logic                     w_run;
  logic                     w_first;
  logic                     w_last;
  logic                     w_prev_c;

  assign w_run   = (r_state == RUN);
  assign w_first = (r_idx == '0);
  assign w_last  = (r_idx == IDX_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_m         <= 1'b0;
      r_cin       <= 1'b0;
      r_chain     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_s     <= req_S;
            r_m     <= req_M;
            r_cin   <= req_cin;
            r_chain <= req_chain;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign w_a_word[gi] = r_a[gi*ALU_W +: ALU_W];
      assign w_b_word[gi] = r_b[gi*ALU_W +: ALU_W];
      assign rsp_do[gi*ALU_W +: ALU_W] = r_rsp_word[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rsp_word[gi] <= '0;
        end else if (w_run && (r_idx == IDX_W'(gi))) begin
          r_rsp_word[gi] <= alu_do;
        end
      end
    end
  endgenerate

  // ALU drive is forced to zero outside RUN so the idle bus is quiet.
  assign alu_a   = w_run ? w_a_word[r_idx] : '0;
  assign alu_b   = w_run ? w_b_word[r_idx] : '0;
  assign alu_S   = w_run ? r_s : 4'h0;
  assign alu_M   = w_run & r_m;
  assign alu_cin = w_run & ((w_first || !r_chain) ? r_cin : (w_prev_c ^ CARRY_INV));

  assign req_ready = !rst && (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;

  alu_chain_flags u_flags (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_first    (w_first),
    .i_last     (w_last),
    .i_alu_c    (alu_C),
    .i_alu_n    (alu_N),
    .i_alu_v    (alu_V),
    .i_alu_z    (alu_Z),
`ifdef ALU_CHAIN_STICKY_V_EN
    .i_done_hs  (r_rsp_valid && rsp_ready),
    .i_v_clr    (v_clr),
    .o_v_sticky (v_sticky),
`endif
    .o_prev_c   (w_prev_c),
    .o_rsp_c    (rsp_C),
    .o_rsp_n    (rsp_N),
    .o_rsp_v    (rsp_V),
    .o_rsp_z    (rsp_Z)
  );

endmodule

// File: tb/tb_alu_chain_seq.sv
// Self-checking bench for alu_chain_seq (WORDS=2) with a behavioural 32-bit ALU
// attached; the wide reference model works directly on 64-bit values.
module tb_alu_chain_seq;
  import alu_chain_pkg::*;

  localparam int WORDS = 2;
  localparam int W     = ALU_W * WORDS;

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic         n;
    logic         v;
    logic         z;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic [3:0]       req_S;
  logic             req_M;
  logic             req_cin;
  logic             req_chain;
  logic [ALU_W-1:0] alu_a;
  logic [ALU_W-1:0] alu_b;
  logic [3:0]       alu_S;
  logic             alu_M;
  logic             alu_cin;
  logic [ALU_W-1:0] alu_do;
  logic             alu_C;
  logic             alu_N;
  logic             alu_V;
  logic             alu_Z;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_do;
  logic             rsp_C;
  logic             rsp_N;
  logic             rsp_V;
  logic             rsp_Z;
`ifdef ALU_CHAIN_STICKY_V_EN
  logic             v_clr;
  logic             v_sticky;
  logic             exp_sticky;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_chain_seq #(.WORDS(WORDS), .CARRY_INV(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_S     (req_S),
    .req_M     (req_M),
    .req_cin   (req_cin),
    .req_chain (req_chain),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_S     (alu_S),
    .alu_M     (alu_M),
    .alu_cin   (alu_cin),
    .alu_do    (alu_do),
    .alu_C     (alu_C),
    .alu_N     (alu_N),
    .alu_V     (alu_V),
    .alu_Z     (alu_Z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_do    (rsp_do),
    .rsp_C     (rsp_C),
    .rsp_N     (rsp_N),
    .rsp_V     (rsp_V),
`ifdef ALU_CHAIN_STICKY_V_EN
    .v_clr     (v_clr),
    .v_sticky  (v_sticky),
`endif
    .rsp_Z     (rsp_Z)
  );

  // Behavioural stand-in for the external 32-bit ALU.
  logic [ALU_W:0]   alu_sum;
  logic [ALU_W-1:0] alu_bb;
  always_comb begin
    alu_sum = '0;
    alu_bb  = '0;
    alu_do  = alu_a;
    alu_C   = 1'b0;
    alu_V   = 1'b0;
    if (alu_M == ALU_M_ARITH) begin
      alu_bb  = (alu_S == ALU_S_SUB) ? ~alu_b : alu_b;
      alu_sum = {1'b0, alu_a} + {1'b0, alu_bb} + {{ALU_W{1'b0}}, alu_cin};
      alu_do  = alu_sum[ALU_W-1:0];
      alu_C   = alu_sum[ALU_W];
      alu_V   = (alu_a[ALU_W-1] == alu_bb[ALU_W-1]) && (alu_do[ALU_W-1] != alu_a[ALU_W-1]);
    end else begin
      case (alu_S)
        ALU_S_AND: alu_do = alu_a & alu_b;
        ALU_S_OR:  alu_do = alu_a | alu_b;
        ALU_S_XOR: alu_do = alu_a ^ alu_b;
        default:   alu_do = alu_a;
      endcase
    end
    alu_N = alu_do[ALU_W-1];
    alu_Z = (alu_do == '0);
  end

  // Reference: the whole wide operation computed as one arithmetic expression.
  function automatic rsp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic m,
                                  input logic cin, input logic chain);
    rsp_t         r;
    logic [W:0]   wide;
    logic [W-1:0] bb;
    logic [32:0]  lo;
    logic [32:0]  hi;
    r = '0;
    if (m == ALU_M_LOGIC) begin
      if (s == ALU_S_AND)      r.d = a & b;
      else if (s == ALU_S_OR)  r.d = a | b;
      else if (s == ALU_S_XOR) r.d = a ^ b;
      else                     r.d = a;
    end else begin
      bb = (s == ALU_S_SUB) ? ~b : b;
      if (chain) begin
        wide = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        r.d  = wide[W-1:0];
        r.c  = wide[W];
      end else begin
        lo  = {1'b0, a[31:0]}  + {1'b0, bb[31:0]}  + {32'd0, cin};
        hi  = {1'b0, a[63:32]} + {1'b0, bb[63:32]} + {32'd0, cin};
        r.d = {hi[31:0], lo[31:0]};
        r.c = hi[32];
      end
      r.v = (a[W-1] == bb[W-1]) && (r.d[W-1] != a[W-1]);
    end
    r.n = r.d[W-1];
    r.z = (r.d == '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m, input logic cin,
                       input logic chain, input int hold);
    rsp_t exp;
    int   n;
    exp = ref_op(a, b, s, m, cin, chain);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_ready"}, W'(req_ready), W'(1));
    req_a = a; req_b = b; req_S = s; req_M = m; req_cin = cin; req_chain = chain;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, "_alu_a_w0"}, W'(alu_a), W'(a[31:0]));
    for (int k = 1; k < WORDS; k++) begin
      check({tag, "_early_valid"}, W'(rsp_valid), W'(0));
      tick();
    end
    tick();
    check({tag, "_rsp_valid"}, W'(rsp_valid), W'(1));
    check({tag, "_rsp_do"}, rsp_do, exp.d);
    check({tag, "_flags_CNVZ"}, W'({rsp_C, rsp_N, rsp_V, rsp_Z}),
          W'({exp.c, exp.n, exp.v, exp.z}));
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, W'(rsp_valid), W'(1));
      check({tag, "_hold_do"}, rsp_do, exp.d);
      check({tag, "_hold_req_ready"}, W'(req_ready), W'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef ALU_CHAIN_STICKY_V_EN
    exp_sticky = exp_sticky | exp.v;
    check({tag, "_v_sticky"}, W'(v_sticky), W'(exp_sticky));
`endif
    check({tag, "_post_valid"}, W'(rsp_valid), W'(0));
    check({tag, "_post_req_ready"}, W'(req_ready), W'(1));
    $display("op %s a=%h b=%h S=%h M=%0d cin=%0d chain=%0d -> do=%h CNVZ=%b%b%b%b",
             tag, a, b, s, m, cin, chain, rsp_do, rsp_C, rsp_N, rsp_V, rsp_Z);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rs;
    logic         rm;
    int           sel;
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_S = '0; req_M = 1'b0;
    req_cin = 1'b0; req_chain = 1'b0; rsp_ready = 1'b0;
`ifdef ALU_CHAIN_STICKY_V_EN
    v_clr = 1'b0; exp_sticky = 1'b0;
`endif
    tick(); tick();
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_rsp_do", rsp_do, '0);
    check("rst_alu_bus", W'({alu_a, alu_S, alu_M, alu_cin}), '0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", W'(req_ready), W'(1));

    do_op("chain_add", 64'h0000_0000_FFFF_FFFF, 64'h1, ALU_S_ADD, ALU_M_ARITH, 1'b0, 1'b1, 0);
    do_op("unchained", 64'h0000_0000_FFFF_FFFF, 64'h1, ALU_S_ADD, ALU_M_ARITH, 1'b0, 1'b0, 0);
    do_op("zero_all", 64'h0, 64'h0, ALU_S_ADD, ALU_M_ARITH, 1'b0, 1'b1, 0);
    do_op("zero_low", 64'h1_0000_0000, 64'h0, ALU_S_ADD, ALU_M_ARITH, 1'b0, 1'b1, 0);
    do_op("backpress", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
          ALU_S_ADD, ALU_M_ARITH, 1'b1, 1'b1, 5);
    do_op("chain_sub", 64'h1_0000_0000, 64'h1, ALU_S_SUB, ALU_M_ARITH, 1'b1, 1'b1, 0);

    // Reset in the first RUN cycle discards the operation.
    req_a = 64'h5555_0000_FFFF_FFFF; req_b = 64'h1; req_S = ALU_S_ADD; req_M = ALU_M_ARITH;
    req_cin = 1'b0; req_chain = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrun_rsp_valid", W'(rsp_valid), W'(0));
    check("midrun_rsp_do", rsp_do, '0);
    check("midrun_flags", W'({rsp_C, rsp_N, rsp_V, rsp_Z}), '0);
    check("midrun_alu_bus", W'({alu_a, alu_b, alu_S, alu_M, alu_cin}), '0);
    check("midrun_req_ready_rst", W'(req_ready), W'(0));
    rst = 1'b0;
    #1;
    check("midrun_req_ready", W'(req_ready), W'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrun_no_rsp", W'(rsp_valid), W'(0));
    end
    $display("op midrun_reset discarded");

`ifdef ALU_CHAIN_STICKY_V_EN
    do_op("sticky_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, ALU_S_ADD, ALU_M_ARITH, 1'b0, 1'b1, 0);
    do_op("sticky_keep", 64'h2, 64'h3, ALU_S_ADD, ALU_M_ARITH, 1'b0, 1'b1, 0);
    v_clr = 1'b1;
    tick();
    v_clr = 1'b0;
    exp_sticky = 1'b0;
    check("sticky_clr", W'(v_sticky), W'(exp_sticky));
    $display("op sticky_clear v_sticky=%0d", v_sticky);
`endif

    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 4));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) ra[31:0] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) rb = ra;
      case (sel)
        0:       begin rs = ALU_S_ADD; rm = ALU_M_ARITH; end
        1:       begin rs = ALU_S_SUB; rm = ALU_M_ARITH; end
        2:       begin rs = ALU_S_AND; rm = ALU_M_LOGIC; end
        3:       begin rs = ALU_S_OR;  rm = ALU_M_LOGIC; end
        default: begin rs = ALU_S_XOR; rm = ALU_M_LOGIC; end
      endcase
      do_op($sformatf("rand%0d", i), ra, rb, rs, rm, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_chain_seq.md
# alu_chain_seq

Multi-word operation sequencer that sits directly upstream of the 32-bit combinational ALU (`ALU32`) and also captures its result. It accepts one WORDS×32-bit request over a valid/ready handshake and issues it to the ALU one 32-bit word per cycle, least-significant first. Carry is chained word-to-word. It collects the per-word results and flags into a wide response. This gives the datapath 64/96/128-bit add/sub/logic on the existing 32-bit ALU.

## Interface
- WORDS, 2, number of 32-bit words per operation (≥1)
- CARRY_INV, 0, 1 = invert `alu_C` before feeding it to the next word's `alu_cin`

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_a, req_b  in  32*WORDS  operands
- req_S  in  4  ALU function select
- req_M  in  1  ALU mode
- req_cin  in  1  carry into word 0
- req_chain  in  1  1 = words k>0 take carry from word k-1; 0 = every word uses req_cin
- alu_a, alu_b  out  32  current word operands
- alu_S  out  4  function select to ALU
- alu_M  out  1  mode to ALU
- alu_cin  out  1  carry in to ALU
- alu_do  in  32  ALU result
- alu_C, alu_N, alu_V, alu_Z  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_do  out  32*WORDS  assembled result
- rsp_C, rsp_N, rsp_V, rsp_Z  out  1  wide-result flags

Decision: one clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `req_ready=1`.
  - Transfer when `req_valid && req_ready`.
  - On transfer, register operands, S, M, cin and chain; set idx=0; go to RUN.
- RUN: drive ALU outputs from registers.
  - `alu_a`/`alu_b` = word idx.
  - `alu_cin` = `req_cin` when idx=0 or chain=0.
  - Otherwise `alu_cin` = registered previous carry, XOR CARRY_INV.
  - Each RUN edge: store `alu_do` into `rsp_do` word idx, store `alu_C` as previous carry, AND `alu_Z` into the zero accumulator, increment idx.
  - After word WORDS-1 go to DONE.
- DONE: `rsp_valid=1`; `rsp_do` and flags are stable.
  - On `rsp_ready` go to IDLE.
  - `req_ready=0` in DONE, so there is no same-cycle re-accept.
- Flags:
  - `rsp_C`, `rsp_N`, `rsp_V` = top word's `alu_C`/`alu_N`/`alu_V`.
  - `rsp_Z` = AND of all word Z flags.
- Reset values: `req_ready=0` while rst is high, 1 afterwards. All other outputs are 0: rsp_*, alu_a, alu_b, alu_S, alu_M, alu_cin.
- Reset mid-RUN or mid-DONE: the operation is discarded and no response is produced. FSM is in IDLE next cycle.
- `rsp_do` words not yet written hold their previous values. They are never visible, because `rsp_valid=0` until all words are written.

## Timing
- Accept at edge E0. RUN spans the WORDS cycles after E0.
- `rsp_valid` rises at edge E0+WORDS. Latency is WORDS cycles from the accept edge.
- `rsp_valid` holds, with `rsp_do` and flags stable, until `rsp_ready`.
- Earliest next accept is one cycle after the response handshake. Peak throughput is one operation per WORDS+2 cycles.
- ALU is purely combinational; its outputs are sampled in the same cycle they are driven.
- `req_ready` is a function of state and rst only. It never depends on `req_valid`.

## Configuration
- `ALU_CHAIN_STICKY_V_EN` defined: adds input `v_clr` (1) and output `v_sticky` (1).
  - `v_sticky` is set on the DONE→IDLE handshake when `rsp_V=1`.
  - It is cleared by rst or `v_clr`.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists and there is no sticky logic.

## Structure
- Package `alu_chain_pkg`:
  - state enum (IDLE/RUN/DONE)
  - `ALU_W=32`
  - function select constants used by the bench
- Sub-module `alu_chain_flags` holds the previous-carry register, the Z accumulator and the top-word flag capture, including the optional sticky-V logic.
- The FSM and operand slicing live in the top level.
- `ALU32` is instantiated beside this block by the integrating level, not inside it.

## Test plan
All scenarios use WORDS=2 with real `ALU32` connected and S/M set to its add code.
- Chained add: a=64'h0000_0000_FFFF_FFFF, b=64'h1, cin=0, chain=1 → `rsp_do`=64'h0000_0001_0000_0000; `rsp_Z=0`; `rsp_valid` at accept+2.
- Unchained: same operands, chain=0 → `rsp_do`=64'h0000_0000_0000_0000; `rsp_Z=1`.
- Zero accumulation: a=64'h0, b=64'h0 → `rsp_Z=1`. Then a=64'h1_0000_0000, b=64'h0 → `rsp_Z=0` (low word zero, high word nonzero).
- Backpressure: hold `rsp_ready=0` for 5 cycles → `rsp_valid`/`rsp_do` stable, `req_ready=0` throughout; accept resumes one cycle after the handshake.
- Reset mid-RUN: assert rst in the first RUN cycle → no `rsp_valid`, all outputs 0, `req_ready=1` once rst drops.
- Sticky-V (macro defined): overflowing add a=64'h7FFF_FFFF_FFFF_FFFF, b=64'h1 → `rsp_V=1`, `v_sticky=1` after the handshake. Next clean op keeps it at 1. `v_clr` pulse clears it to 0.
